// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers {inst, pc} in a prefetch FIFO.
// Optional backward-taken branch prediction is enabled by defining FETCH_BTFN_PREDICT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    output logic         out_valid,
    output logic [63:0]  out_data,
    output logic         out_predict
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                       state_q, state_d;
    logic [31:0]                  fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]                outst_q, outst_d;
    logic [OW-1:0]                drop_q, drop_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [PW-1:0]                rd_q, wr_q;
    logic [FIFO_DEPTH-1:0][63:0]  fifo_q;
    logic [MAX_OUTSTANDING-1:0][31:0] pcq_q;
    logic [QW-1:0]                pcq_hd_q, pcq_tl_q;

    logic        req, accept, rsp_fire, push, pop, credit_ok, pred_fire;
    logic [31:0] rsp_pc, pred_target;

    function automatic logic [QW-1:0] qnext(input logic [QW-1:0] i);
        return (int'(i) == MAX_OUTSTANDING - 1) ? '0 : i + QW'(1);
    endfunction

    // Responses with nothing outstanding (stale pre-reset traffic) are ignored.
    assign rsp_fire  = imem.imem_rsp_valid && (outst_q != '0);
    assign rsp_pc    = pcq_q[pcq_hd_q];
    assign push      = rsp_fire && (drop_q == '0) && !flush;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && !stall && !flush;
    assign out_data  = out_valid ? fifo_q[rd_q] : {NOP, 32'h0};

    // A FIFO slot is reserved for every in-flight request, so the FIFO cannot overflow.
    assign credit_ok = (int'(outst_q) < MAX_OUTSTANDING) &&
                       (int'(outst_q) + int'(cnt_q) < FIFO_DEPTH);
    assign req       = (state_q == FETCH) && credit_ok && !flush && !pred_fire;
    assign accept    = req && imem.imem_ready;

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;

`ifdef FETCH_BTFN_PREDICT_EN
    logic [FIFO_DEPTH-1:0] pred_q;
    logic [31:0]           inst;

    assign inst        = imem.imem_rsp_data;
    assign pred_fire   = push && (inst[6:0] == 7'b1100011) && inst[31];
    assign pred_target = rsp_pc + {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign out_predict = out_valid && pred_q[rd_q];

    always_ff @(posedge clk) begin
        if (push) pred_q[wr_q] <= pred_fire;
    end
`else
    assign pred_fire   = 1'b0;
    assign pred_target = '0;
    assign out_predict = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + OW'(accept) - OW'(rsp_fire);
        drop_d     = drop_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);

        if (accept)                     fetch_pc_d = fetch_pc_q + 32'd4;
        if (rsp_fire && drop_q != '0)   drop_d     = drop_q - OW'(1);
        // A predicted branch behaves like a flush that keeps the older FIFO entries.
        if (pred_fire) begin
            fetch_pc_d = pred_target;
            drop_d     = outst_q - OW'(1);
        end
        if (flush) begin
            fetch_pc_d = flush_pc;
            drop_d     = outst_q - OW'(rsp_fire);
            cnt_d      = '0;
        end

        case (state_q)
            IDLE:    state_d = FETCH;
            default: state_d = (drop_d != '0) ? DRAIN : FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            pcq_hd_q   <= '0;
            pcq_tl_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            if (flush) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + PW'(1);
                if (pop)  rd_q <= rd_q + PW'(1);
            end
            if (accept)   pcq_tl_q <= qnext(pcq_tl_q);
            if (rsp_fire) pcq_hd_q <= qnext(pcq_hd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push)   fifo_q[wr_q]    <= {imem.imem_rsp_data, rsp_pc};
        if (accept) pcq_q[pcq_tl_q] <= fetch_pc_q;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order imem slave plus a queue-level model of the fetch stream.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk, reset, stall, flush;
    logic [31:0] flush_pc;
    logic        out_valid, out_predict;
    logic [63:0] out_data;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset), .imem(bus), .stall(stall), .flush(flush),
        .flush_pc(flush_pc), .out_valid(out_valid), .out_data(out_data), .out_predict(out_predict)
    );

    int checks = 0, errors = 0;
    int rdy_pct = 100, rsp_pct = 100;
    bit model_en = 1, plant = 0;

    logic [31:0] sq[$];
    logic [63:0] mq[$];
    logic [31:0] mo[$];
    int          mdrop;
    logic [31:0] mpc;
    bit          midle;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] h;
        if (plant && a == 32'h10) return 32'hFE00_0CE3;
        h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return {h[31:7], 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // imem slave: in order, random accept and response delay
    always @(negedge clk)
        if (!reset && bus.imem_req && bus.imem_ready) sq.push_back(bus.imem_addr);

    initial begin
        logic [31:0] a;
        bus.imem_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
        forever begin
            @(posedge clk); #2;
            bus.imem_ready = ($urandom_range(99) < rdy_pct);
            if (reset) begin
                sq.delete();
                bus.imem_rsp_valid = 0;
            end else if (sq.size() != 0 && $urandom_range(99) < rsp_pct) begin
                a = sq.pop_front();
                bus.imem_rsp_valid = 1;
                bus.imem_rsp_data  = memw(a);
            end else begin
                bus.imem_rsp_valid = 0;
            end
        end
    end

    // Model: FIFO contents, in-flight addresses, pending discards, next fetch address.
    always @(negedge clk) begin
        logic [63:0] ed;
        logic [31:0] a;
        bit ev, er;
        if (reset) begin
            mq.delete(); mo.delete(); mdrop = 0; mpc = 32'h0; midle = 1;
        end else if (model_en) begin
            ev = (mq.size() != 0);
            ed = ev ? mq[0] : {32'h13, 32'h0};
            er = !midle && mdrop == 0 && mo.size() < MAXO && (mo.size() + mq.size()) < DEPTH && !flush;
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_data", out_data, ed);
            chk("imem_req", 64'(bus.imem_req), 64'(er));
            chk("out_predict", 64'(out_predict), 64'(0));
            if (er) chk("imem_addr", 64'(bus.imem_addr), 64'(mpc));
            if (ev && !stall && !flush) void'(mq.pop_front());
            if (bus.imem_rsp_valid && mo.size() != 0) begin
                a = mo.pop_front();
                if (mdrop > 0) mdrop--;
                else if (!flush) mq.push_back({memw(a), a});
            end
            if (er && bus.imem_ready) begin
                mo.push_back(mpc);
                mpc = mpc + 32'd4;
            end
            if (flush) begin
                mq.delete();
                mdrop = mo.size();
                mpc = flush_pc;
            end
            midle = 0;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cyc(); reset = 1; cyc(); cyc(); reset = 0;
    endtask

    task automatic wait_valid(output bit ok, output int n);
        ok = 0; n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                ok = 1;
                return;
            end
        end
        chk("wait_valid_timeout", 64'(ok), 64'(1));
    endtask

    initial begin
        bit ok;
        int n;
        logic [31:0] r;
        reset = 1; stall = 0; flush = 0; flush_pc = 0;

        // 1: straight-line fetch, first output two cycles after first accept
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, {32'h13, 32'h0});
        chk("rst_imem_req", 64'(bus.imem_req), 64'(0));
        chk("rst_out_predict", 64'(out_predict), 64'(0));
        wait_valid(ok, n);
        chk("first_latency", 64'(n), 64'(3));
        chk("seq_A", out_data, {memw(32'h0), 32'h0});
        @(negedge clk); chk("seq_B", out_data, {memw(32'h4), 32'h4});
        @(negedge clk); chk("seq_C", out_data, {memw(32'h8), 32'h8});

        // 2: stall fills the FIFO, then release drains it in order
        stall = 1;
        do_reset();
        repeat (8) @(negedge clk);
        chk("full_req", 64'(bus.imem_req), 64'(0));
        chk("full_valid", 64'(out_valid), 64'(1));
        chk("full_head", out_data, {memw(32'h0), 32'h0});
        cyc(); stall = 0;
        for (int k = 0; k < 6; k++) begin
            wait_valid(ok, n);
            chk("drain_pc", 64'(out_data[31:0]), 64'(4 * k));
        end

        // 3: flush with two requests in flight
        rsp_pct = 0;
        do_reset();
        cyc(); cyc(); cyc();
        flush = 1; flush_pc = 32'h100;
        @(negedge clk); chk("flush_req", 64'(bus.imem_req), 64'(0));
        cyc(); flush = 0; rsp_pct = 100;
        wait_valid(ok, n);
        chk("flush_target", out_data, {memw(32'h100), 32'h100});

        // 4: flush and stall together
        stall = 1;
        do_reset();
        repeat (8) @(negedge clk);
        cyc(); flush = 1; flush_pc = 32'h200;
        @(negedge clk); chk("fs_req", 64'(bus.imem_req), 64'(0));
        cyc(); flush = 0;
        @(negedge clk);
        chk("fs_valid", 64'(out_valid), 64'(0));
        chk("fs_data", out_data, {32'h13, 32'h0});
        cyc(); stall = 0;
        wait_valid(ok, n);
        chk("fs_target", out_data, {memw(32'h200), 32'h200});

        // 5: imem not ready holds the request; then PC wraparound
        rdy_pct = 0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_req", 64'(bus.imem_req), 64'(1));
            chk("hold_addr", 64'(bus.imem_addr), 64'(0));
            chk("hold_valid", 64'(out_valid), 64'(0));
        end
        cyc(); rdy_pct = 100;
        wait_valid(ok, n);
        chk("hold_first", out_data, {memw(32'h0), 32'h0});
        cyc(); flush = 1; flush_pc = 32'hFFFF_FFFC;
        cyc(); flush = 0;
        wait_valid(ok, n); chk("wrap_pc0", 64'(out_data[31:0]), 64'(32'hFFFF_FFFC));
        wait_valid(ok, n); chk("wrap_pc1", 64'(out_data[31:0]), 64'(0));

        // random traffic
        rdy_pct = 70; rsp_pct = 60;
        for (int h = 0; h < 2; h++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                cyc();
                stall = ($urandom_range(99) < 30);
                flush = ($urandom_range(99) < 3);
                r = $urandom;
                flush_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | (r & 32'hC)) : (r & 32'hFFFF_FFFC);
            end
            cyc(); stall = 0; flush = 0;
        end

`ifdef FETCH_BTFN_PREDICT_EN
        begin
            bit got_br, after, saw14;
            logic [31:0] pc;
            got_br = 0; after = 0; saw14 = 0;
            model_en = 0; plant = 1; rdy_pct = 100; rsp_pct = 100;
            do_reset();
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid) begin
                    pc = out_data[31:0];
                    if (got_br && !after) begin
                        chk("pred_next_pc", 64'(pc), 64'(32'h8));
                        after = 1;
                    end
                    if (pc == 32'h14) saw14 = 1;
                    if (pc == 32'h10 && !got_br) begin
                        chk("pred_bit", 64'(out_predict), 64'(1));
                        chk("pred_inst", out_data, {32'hFE00_0CE3, 32'h10});
                        got_br = 1;
                    end else if (pc != 32'h10) begin
                        chk("pred_other", 64'(out_predict), 64'(0));
                    end
                end
            end
            chk("pred_seen", 64'(got_br), 64'(1));
            chk("pred_dropped_14", 64'(saw14), 64'(0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
